fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 redirect_valid  input  1  jump/branch taken this cycle (driven from jump unit pc_reset_jump).
REQ-005 redirect_pc  input  32  redirect target (jump unit pc_save_value).
REQ-006 stall  input  1  downstream not accepting instruction.
REQ-007 imem_req  output  1  fetch request to instruction memory.
REQ-008 imem_addr  output  32  fetch address, equals current PC while imem_req=1.
REQ-009 imem_gnt  input  1  memory accepted request this cycle.
REQ-010 imem_rvalid  input  1  read data valid; exactly one per granted request, any later cycle.
REQ-011 imem_rdata  input  32  fetched instruction word.
REQ-012 instr_valid  output  1  instr_out/instr_pc valid for decode.
REQ-013 instr_out  output  32  registered instruction word.
REQ-014 instr_pc  output  32  PC of instr_out.
REQ-015 flush  output  1  combinational, equals redirect_valid; kills younger pipeline stages.
REQ-016 misalign_err  output  1  sticky misaligned-redirect flag (see Configuration).

Function
REQ-017 States: IDLE, REQ, WAIT, HOLD, SQUASH, HALT; one request outstanding max.
REQ-018 IDLE -> REQ unconditionally next cycle; imem_req=0 in IDLE.
REQ-019 REQ: imem_req=1, imem_addr=pc; imem_gnt=1 -> WAIT, else stay REQ with address stable.
REQ-020 WAIT: imem_rvalid=1 -> instr_out<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4; next state HOLD.
REQ-021 Fetch-to-instr_valid latency: one cycle after imem_rvalid.
REQ-022 HOLD: instruction consumed when instr_valid=1 and stall=0; then instr_valid<=0 unless new data captured, state -> REQ; stall=1 keeps outputs and state unchanged.
REQ-023 pc+4 is modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-024 redirect_valid=1 has priority over stall and over normal sequencing in every state except HALT.
REQ-025 Redirect with no outstanding request (IDLE, HOLD, REQ without gnt): pc<=redirect_pc, instr_valid<=0, state -> REQ.
REQ-026 Redirect in WAIT, or in REQ with imem_gnt=1 same cycle: pc<=redirect_pc, instr_valid<=0, state -> SQUASH.
REQ-027 Redirect in WAIT coincident with imem_rvalid: response dropped, pc<=redirect_pc, state -> REQ.
REQ-028 SQUASH: imem_req=0; imem_rvalid=1 discarded (no output change) -> REQ; further redirect updates pc, stays SQUASH.
REQ-029 instr_valid never asserts for a word fetched before the most recent redirect.

Reset
REQ-030 On rising clk with rst_n=0: pc=RESET_PC, state=IDLE, instr_valid=0, instr_out=0, instr_pc=0, misalign_err=0, imem_req=0.
REQ-031 Reset mid-transaction abandons any outstanding request; a late imem_rvalid after reset while in IDLE/REQ is ignored.

Configuration
REQ-032 Macro FETCH_ALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]!=0 sets misalign_err=1, state -> HALT, imem_req=0, instr_valid=0 until reset.
REQ-033 Macro undefined: redirect_pc[1:0] forced to 2'b00, misalign_err tied 0, HALT unreachable.

Structure
REQ-034 Shared package holds fetch_state_t enum and constant INSTR_BYTES=4.
REQ-035 Single module, no sub-modules; PC register and FSM in one always_ff, outputs decoded in always_comb.

Verification
REQ-036 Reset, gnt immediate, rvalid +1 cycle, rdata=32'h0000_0013 -> instr_valid=1, instr_pc=0, next imem_addr=4.
REQ-037 stall=1 for 3 cycles in HOLD -> instr_out/instr_pc stable, imem_req=0; release -> REQ at pc+4.
REQ-038 redirect_pc=32'h0000_0100 during WAIT, rvalid 2 cycles later -> rdata dropped, flush=1 one cycle, next imem_addr=32'h100.
REQ-039 pc=32'hFFFF_FFFC fetch completes -> next imem_addr=32'h0000_0000.
REQ-040 redirect and stall together in HOLD -> instr_valid=0 next cycle, request to redirect target.
REQ-041 FETCH_ALIGN_CHECK_EN, redirect_pc=32'h0000_0102 -> misalign_err=1, imem_req=0 until rst_n=0; undefined -> fetch at 32'h100.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_sequencer_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StHold,
        StSquash,
        StHalt
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding imem request, redirect/squash handling.
// Optional misaligned-redirect trap enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        flush,
    output logic        misalign_err
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         instr_valid_q, instr_valid_d;
    logic [31:0]  instr_out_q, instr_out_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic         misalign_q, misalign_d;

    logic [31:0]  target_pc;
    logic         target_bad;

`ifdef FETCH_ALIGN_CHECK_EN
    assign target_pc  = redirect_pc;
    assign target_bad = |redirect_pc[1:0];
`else
    assign target_pc  = {redirect_pc[31:2], 2'b00};
    assign target_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            instr_valid_q <= 1'b0;
            instr_out_q   <= 32'h0;
            instr_pc_q    <= 32'h0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_valid_q <= instr_valid_d;
            instr_out_q   <= instr_out_d;
            instr_pc_q    <= instr_pc_d;
            misalign_q    <= misalign_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_valid_d = instr_valid_q;
        instr_out_d   = instr_out_q;
        instr_pc_d    = instr_pc_q;
        misalign_d    = misalign_q;

        if (state_q != StHalt && redirect_valid) begin
            pc_d          = target_pc;
            instr_valid_d = 1'b0;
            if (target_bad) begin
                misalign_d = 1'b1;
                state_d    = StHalt;
            end else begin
                // A request still in flight must have its response drained in SQUASH.
                unique case (state_q)
                    StReq:    state_d = imem_gnt ? StSquash : StReq;
                    StWait:   state_d = imem_rvalid ? StReq : StSquash;
                    StSquash: state_d = imem_rvalid ? StReq : StSquash;
                    default:  state_d = StReq;
                endcase
            end
        end else begin
            unique case (state_q)
                StIdle: state_d = StReq;
                StReq: begin
                    if (imem_gnt) state_d = StWait;
                end
                StWait: begin
                    if (imem_rvalid) begin
                        instr_out_d   = imem_rdata;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        pc_d          = pc_q + 32'(INSTR_BYTES);
                        state_d       = StHold;
                    end
                end
                StHold: begin
                    if (instr_valid_q && !stall) begin
                        instr_valid_d = 1'b0;
                        state_d       = StReq;
                    end
                end
                StSquash: begin
                    if (imem_rvalid) state_d = StReq;
                end
                StHalt: begin
                    instr_valid_d = 1'b0;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        imem_req     = (state_q == StReq);
        imem_addr    = pc_q;
        instr_valid  = instr_valid_q;
        instr_out    = instr_out_q;
        instr_pc     = instr_pc_q;
        flush        = redirect_valid;
        misalign_err = misalign_q;
    end

endmodule
